// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - loader state encoding and frame field widths
package imem_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - pairs stream bytes into words and drives the imem write port
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load_hi,
    input  logic              load_lo,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [LEN_W-1:0]  word_count,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] wr_data
);

    logic [BYTE_W-1:0] hi_q;

    // addr/wr_data are only updated on a write so they hold between strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q       <= '0;
            word_count <= '0;
            wr_en      <= 1'b0;
            addr       <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                hi_q       <= '0;
                word_count <= '0;
            end else if (load_hi) begin
                hi_q <= byte_data;
            end else if (load_lo) begin
                wr_en      <= 1'b1;
                addr       <= ADDR_W'(word_count);
                wr_data    <= {hi_q, byte_data};
                word_count <= word_count + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream boot loader for the instruction memory; IMEM_LOADER_CHECKSUM_EN enables the trailing XOR check
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t END_ST = CHECK;
    logic [BYTE_W-1:0] csum_q;
`else
    localparam loader_state_t END_ST = DONE;
`endif

    loader_state_t     state, next_state;
    logic [BYTE_W-1:0] len_hi_q;
    logic [LEN_W-1:0]  n_q;
    logic [LEN_W-1:0]  word_count;
    logic [LEN_W-1:0]  len_in;
    logic              accept;
    logic              clear, load_hi, load_lo, len_hi_ld, len_ld;

    assign accept = in_valid && in_ready;
    assign len_in = {len_hi_q, in_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        clear      = 1'b0;
        load_hi    = 1'b0;
        load_lo    = 1'b0;
        len_hi_ld  = 1'b0;
        len_ld     = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    next_state = LEN_HI;
                    clear      = 1'b1;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_hi_ld  = 1'b1;
                    next_state = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_ld = 1'b1;
                    if (len_in > LEN_W'(DEPTH))
                        next_state = ERR;
                    else if (len_in == '0)
                        next_state = END_ST;
                    else
                        next_state = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    load_hi    = 1'b1;
                    next_state = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    load_lo    = 1'b1;
                    next_state = (word_count + LEN_W'(1) < n_q) ? DATA_HI : END_ST;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept)
                    next_state = (in_data == csum_q) ? DONE : ERR;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they track the state register exactly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi_q <= '0;
            n_q      <= '0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            if (len_hi_ld) len_hi_q <= in_data;
            if (len_ld)    n_q      <= len_in;
            in_ready <= (next_state == LEN_HI) || (next_state == LEN_LO) ||
                        (next_state == DATA_HI) || (next_state == DATA_LO) ||
                        (next_state == CHECK);
            done     <= (next_state == DONE);
            error    <= (next_state == ERR);
            cpu_hold <= (next_state != DONE);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (clear) begin
            csum_q <= '0;
        end else if (load_hi || load_lo) begin
            csum_q <= csum_q ^ in_data;
        end
    end
`endif

    word_assembler #(
        .ADDR_W(ADDR_W)
    ) u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load_hi   (load_hi),
        .load_lo   (load_lo),
        .byte_data (in_data),
        .word_count(word_count),
        .wr_en     (imem_wr_en),
        .addr      (imem_addr),
        .wr_data   (imem_wr_data)
    );

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_wr_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  frame_q[$];
    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];

    imem_loader #(
        .DEPTH (256),
        .ADDR_W(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .imem_wr_en  (imem_wr_en),
        .imem_addr   (imem_addr),
        .imem_wr_data(imem_wr_data),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wr_data);
        end
    end

    task automatic do_reset();
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 40) begin
            n_fail++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h5A;
    endtask

    task automatic send_frame(input bit gaps, input int start_at);
        foreach (frame_q[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_data = 8'($urandom);
                    @(negedge clk);
                end
            end
            if (i == start_at) pulse_start();
            push(frame_q[i]);
        end
    endtask

    task automatic set_basic_frame();
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 7;
        if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        if (imem_wr_en !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_en: got %b required 0", imem_wr_en); end
        if (imem_addr !== 16'h0)   begin n_fail++; $display("FAIL reset_addr: got %h required 0000", imem_addr); end
        if (imem_wr_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0000", imem_wr_data); end
        if (cpu_hold !== 1'b1)     begin n_fail++; $display("FAIL reset_hold: got %b required 1", cpu_hold); end
        if (done !== 1'b0)         begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        if (error !== 1'b0)        begin n_fail++; $display("FAIL reset_error: got %b required 0", error); end
    endtask

    task automatic test_frame(input bit gaps, input int start_at);
        do_reset();
        set_basic_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h40);
`endif
        pulse_start();
        n_checks += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL frame_ready_after_start: got %b required 1", in_ready); end
        if (done !== 1'b0)     begin n_fail++; $display("FAIL frame_done_early: got %b required 0", done); end
        send_frame(gaps, start_at);
        n_checks += 3;
        if (done !== 1'b1)     begin n_fail++; $display("FAIL frame_done: got %b required 1", done); end
        if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL frame_hold: got %b required 0", cpu_hold); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL frame_ready_end: got %b required 0", in_ready); end
        @(negedge clk);
        n_checks += 3;
        if (log_addr.size() != 2) begin
            n_fail++; $display("FAIL frame_write_count: got %0d required 2", log_addr.size());
        end else begin
            if (log_addr[0] !== 16'h0000 || log_data[0] !== 16'h1234) begin
                n_fail++; $display("FAIL frame_word0: got %h@%h required 1234@0000", log_data[0], log_addr[0]);
            end
            if (log_addr[1] !== 16'h0001 || log_data[1] !== 16'hABCD) begin
                n_fail++; $display("FAIL frame_word1: got %h@%h required abcd@0001", log_data[1], log_addr[1]);
            end
        end
        n_checks += 3;
        if (imem_wr_en !== 1'b0)    begin n_fail++; $display("FAIL frame_wr_en_idle: got %b required 0", imem_wr_en); end
        if (imem_addr !== 16'h0001) begin n_fail++; $display("FAIL frame_addr_hold: got %h required 0001", imem_addr); end
        if (error !== 1'b0)         begin n_fail++; $display("FAIL frame_error: got %b required 0", error); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        do_reset();
        set_basic_frame();
        frame_q.push_back(8'h41);
        pulse_start();
        send_frame(1'b0, -1);
        @(negedge clk);
        n_checks += 4;
        if (error !== 1'b1)    begin n_fail++; $display("FAIL badcs_error: got %b required 1", error); end
        if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL badcs_hold: got %b required 1", cpu_hold); end
        if (done !== 1'b0)     begin n_fail++; $display("FAIL badcs_done: got %b required 0", done); end
        if (log_addr.size() != 2) begin n_fail++; $display("FAIL badcs_writes: got %0d required 2", log_addr.size()); end
    endtask
`endif

    task automatic test_oversize();
        do_reset();
        pulse_start();
        push(8'h01);
        push(8'h01);
        n_checks += 4;
        if (error !== 1'b1)    begin n_fail++; $display("FAIL over_error: got %b required 1", error); end
        if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL over_hold: got %b required 1", cpu_hold); end
        if (done !== 1'b0)     begin n_fail++; $display("FAIL over_done: got %b required 0", done); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL over_ready: got %b required 0", in_ready); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (log_addr.size() != 0) begin n_fail++; $display("FAIL over_writes: got %0d required 0", log_addr.size()); end
        pulse_start();
        n_checks += 2;
        if (error !== 1'b0)    begin n_fail++; $display("FAIL restart_error: got %b required 0", error); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL restart_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_zero_len();
        do_reset();
        frame_q = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h00);
`endif
        pulse_start();
        send_frame(1'b0, -1);
        n_checks += 2;
        if (done !== 1'b1)     begin n_fail++; $display("FAIL zero_done: got %b required 1", done); end
        if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL zero_hold: got %b required 0", cpu_hold); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (log_addr.size() != 0) begin n_fail++; $display("FAIL zero_writes: got %0d required 0", log_addr.size()); end
    endtask

    task automatic test_full_depth();
        do_reset();
        frame_q = '{8'h01, 8'h00};
        for (int i = 0; i < 256; i++) begin
            frame_q.push_back(8'h00);
            frame_q.push_back(8'(i));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h00);
`endif
        pulse_start();
        send_frame(1'b0, -1);
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL depth_done: got %b required 1", done); end
        @(negedge clk);
        n_checks++;
        if (log_addr.size() != 256) begin
            n_fail++; $display("FAIL depth_writes: got %0d required 256", log_addr.size());
        end else begin
            n_checks++;
            if (log_addr[255] !== 16'h00FF || log_data[255] !== 16'h00FF) begin
                n_fail++; $display("FAIL depth_last: got %h@%h required 00ff@00ff", log_data[255], log_addr[255]);
            end
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        pulse_start();
        push(8'h00);
        push(8'h02);
        push(8'h12);
        push(8'h34);
        #2 reset = 1'b0;
        #1;
        n_checks += 8;
        if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL midrst_ready: got %b required 0", in_ready); end
        if (imem_wr_en !== 1'b0)    begin n_fail++; $display("FAIL midrst_wr_en: got %b required 0", imem_wr_en); end
        if (imem_addr !== 16'h0)    begin n_fail++; $display("FAIL midrst_addr: got %h required 0000", imem_addr); end
        if (imem_wr_data !== 16'h0) begin n_fail++; $display("FAIL midrst_data: got %h required 0000", imem_wr_data); end
        if (cpu_hold !== 1'b1)      begin n_fail++; $display("FAIL midrst_hold: got %b required 1", cpu_hold); end
        if (done !== 1'b0)          begin n_fail++; $display("FAIL midrst_done: got %b required 0", done); end
        if (error !== 1'b0)         begin n_fail++; $display("FAIL midrst_error: got %b required 0", error); end
        if (log_addr.size() != 1)   begin n_fail++; $display("FAIL midrst_first_write: got %0d required 1", log_addr.size()); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        log_addr.delete();
        log_data.delete();
        set_basic_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h40);
`endif
        pulse_start();
        send_frame(1'b0, -1);
        @(negedge clk);
        n_checks += 2;
        if (done !== 1'b1) begin n_fail++; $display("FAIL midrst_reload_done: got %b required 1", done); end
        if (log_addr.size() != 2) begin
            n_fail++; $display("FAIL midrst_reload_writes: got %0d required 2", log_addr.size());
        end else begin
            n_checks++;
            if (log_data[1] !== 16'hABCD) begin n_fail++; $display("FAIL midrst_reload_word1: got %h required abcd", log_data[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_frame(1'b0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_oversize();
        test_zero_len();
        test_frame(1'b1, 3);
        test_full_depth();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
